// File: rtl/tlp_wr_chunk_sched.sv
// tlp_wr_chunk_sched: turns one AXI write burst at a time into a series of MemWr TLP chunks.
// Each chunk is at most CHUNK_MAX_BEATS beats and never crosses a 4 KB boundary.
// Latency: the header is offered one cycle after AW is accepted. Payload is a zero-latency W pass-through.
// Backpressure: hdr_ready holds HDR, pl_ready drives w_ready directly, and b_ready holds RESP.
// Ports: clk/rst; cfg_bdf; AXI AW/W/B slave side; hdr_* header master; pl_* payload master.
module tlp_wr_chunk_sched #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int CHUNK_MAX_BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           cfg_bdf,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]            aw_len,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_last,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [ADDR_WIDTH-1:0] hdr_addr,
  output logic [9:0]            hdr_length,
  output logic [15:0]           hdr_bdf,
  output logic                  hdr_is_memwrite,
  output logic                  pl_valid,
  input  logic                  pl_ready,
  output logic [DATA_WIDTH-1:0] pl_data,
  output logic                  pl_last
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [6:0] MAXB7 = 7'(CHUNK_MAX_BEATS);
  localparam logic [8:0] MAXB9 = 9'(CHUNK_MAX_BEATS);

  logic [1:0]            state;
  logic                  live;       // low while in reset so aw_ready stays 0 until the first edge
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [8:0]            remaining;  // burst beats not yet covered by a finished chunk (max 256)
  logic [6:0]            beat_cnt;
  logic [6:0]            chunk_q;
  logic                  err;

  logic [7:0]            room_beats; // 32-byte beats left before the next 4 KB line, 1..128
  logic [8:0]            room9;
  logic [6:0]            chunk;
  logic                  beat;
  logic                  chunk_end;
  logic                  burst_end;

  // Addresses are 32-byte aligned, so the room to the 4 KB line can be counted in beats.
  assign room_beats = 8'd128 - {1'b0, addr_q[11:5]};
  assign room9      = {1'b0, room_beats};

  always_comb begin
    chunk = MAXB7;
    if (remaining <= room9 && remaining <= MAXB9) begin
      chunk = remaining[6:0];
    end else if (room9 <= MAXB9) begin
      chunk = room9[6:0];
    end
  end

  assign beat      = (state == S_DATA) && w_valid && pl_ready;
  assign chunk_end = (beat_cnt == 7'd1);
  assign burst_end = chunk_end && (remaining == {2'b00, chunk_q});

  assign aw_ready        = live && (state == S_IDLE);
  assign hdr_valid       = (state == S_HDR);
  assign hdr_addr        = addr_q;
  assign hdr_length      = {chunk, 3'b000};
  assign hdr_bdf         = cfg_bdf;
  assign hdr_is_memwrite = 1'b1;
  assign pl_valid        = (state == S_DATA) && w_valid;
  assign w_ready         = (state == S_DATA) && pl_ready;
  assign pl_data         = w_data;
  assign pl_last         = (state == S_DATA) && chunk_end;
  assign b_valid         = (state == S_RESP);
  assign b_id            = id_q;
  assign b_resp          = err ? 2'b10 : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      live      <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      chunk_q   <= '0;
      err       <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        S_IDLE: begin
          if (aw_valid && aw_ready) begin
            id_q      <= aw_id;
            addr_q    <= aw_addr & ~ADDR_WIDTH'(32'h1f);
            remaining <= {1'b0, aw_len} + 9'd1;
            err       <= 1'b0;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (hdr_ready) begin
            beat_cnt <= chunk;
            chunk_q  <= chunk;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat) begin
            // w_last must match the aw_len-derived final beat; a mismatch is only reported.
            if (w_last != burst_end) err <= 1'b1;
            beat_cnt <= beat_cnt - 7'd1;
            if (chunk_end) begin
              addr_q    <= addr_q + (ADDR_WIDTH'(chunk_q) << 5);
              remaining <= remaining - {2'b00, chunk_q};
              state     <= burst_end ? S_RESP : S_HDR;
            end
          end
        end
        default: begin
          if (b_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_wr_chunk_sched.sv
module tb_tlp_wr_chunk_sched;

  localparam int CMAX = 4;
  localparam logic [15:0] BDF = 16'hA5C3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         aw_valid = 1'b0, aw_ready;
  logic [3:0]   aw_id = '0;
  logic [31:0]  aw_addr = '0;
  logic [7:0]   aw_len = '0;
  logic         w_valid = 1'b0, w_ready;
  logic [255:0] w_data = '0;
  logic         w_last = 1'b0;
  logic         b_valid, b_ready = 1'b1;
  logic [3:0]   b_id;
  logic [1:0]   b_resp;
  logic         hdr_valid, hdr_ready = 1'b1;
  logic [31:0]  hdr_addr;
  logic [9:0]   hdr_length;
  logic [15:0]  hdr_bdf;
  logic         hdr_is_memwrite;
  logic         pl_valid, pl_ready = 1'b1;
  logic [255:0] pl_data;
  logic         pl_last;

  tlp_wr_chunk_sched #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(256), .CHUNK_MAX_BEATS(CMAX)) dut (
    .clk(clk), .rst(rst), .cfg_bdf(BDF),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_addr(hdr_addr), .hdr_length(hdr_length),
    .hdr_bdf(hdr_bdf), .hdr_is_memwrite(hdr_is_memwrite),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data), .pl_last(pl_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Expected transactions from the model.
  logic [31:0]  eh_addr[$];
  logic [9:0]   eh_len[$];
  logic [255:0] ep_data[$];
  bit           ep_last[$];
  logic [3:0]   eb_id[$];
  logic [1:0]   eb_resp[$];
  // Observed transactions, for literal checks.
  logic [31:0]  oh_addr[$];
  logic [9:0]   oh_len[$];
  int           ol_idx[$];
  logic [3:0]   ob_id[$];
  logic [1:0]   ob_resp[$];
  int           pl_cnt = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] beat_val(input int seed, input int i);
    logic [31:0] w;
    w = 32'(seed * 65536 + i);
    return {8{w}};
  endfunction

  // Burst model: split by remaining beats, chunk limit and 4 KB room, in plain arithmetic.
  task automatic model_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                             input int last_at, input int seed);
    logic [31:0] a;
    int rem, c, room, k;
    a = addr & 32'hFFFF_FFE0;
    rem = len + 1;
    k = 0;
    while (rem > 0) begin
      c = rem;
      if (c > CMAX) c = CMAX;
      room = (4096 - int'(a[11:0])) / 32;
      if (c > room) c = room;
      eh_addr.push_back(a);
      eh_len.push_back(10'(c * 8));
      for (int j = 0; j < c; j++) begin
        ep_data.push_back(beat_val(seed, k));
        ep_last.push_back(j == c - 1);
        k++;
      end
      a = a + 32'(c * 32);
      rem -= c;
    end
    eb_id.push_back(id);
    eb_resp.push_back((last_at == len) ? 2'b00 : 2'b10);
  endtask

  task automatic wait_hs(input bit use_w, input string name);
    bit ok;
    int t;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = use_w ? w_ready : aw_ready;
      step();
      t++;
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic send_aw(input logic [31:0] addr, input int len, input logic [3:0] id);
    aw_valid = 1'b1; aw_addr = addr; aw_len = 8'(len); aw_id = id;
    wait_hs(1'b0, "aw_timeout");
    aw_valid = 1'b0;
  endtask

  task automatic send_beat(input int seed, input int i, input bit last);
    w_valid = 1'b1; w_data = beat_val(seed, i); w_last = last;
    wait_hs(1'b1, "w_timeout");
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int last_at, input int seed);
    int t;
    model_burst(addr, len, id, last_at, seed);
    send_aw(addr, len, id);
    for (int i = 0; i <= len; i++) send_beat(seed, i, i == last_at);
    t = 0;
    while (eb_id.size() != 0 && t < 300) begin
      step();
      t++;
    end
    chk("burst_done", eb_id.size(), 0);
  endtask

  // Compare process: every cycle outside reset, outputs are set against the model's queue heads.
  always @(negedge clk) begin
    if (!rst) begin
      if (!pl_ready) chk("w_ready_gated", w_ready, 1'b0);
      if (!w_valid) chk("pl_valid_gated", pl_valid, 1'b0);
      if (hdr_valid) begin
        if (eh_addr.size() == 0) chk("hdr_unexpected", hdr_valid, 1'b0);
        else begin
          chk("hdr_addr", hdr_addr, eh_addr[0]);
          chk("hdr_length", hdr_length, eh_len[0]);
          chk("hdr_bdf", hdr_bdf, BDF);
          chk("hdr_memwr", hdr_is_memwrite, 1'b1);
          if (hdr_ready) begin
            oh_addr.push_back(hdr_addr);
            oh_len.push_back(hdr_length);
            void'(eh_addr.pop_front());
            void'(eh_len.pop_front());
          end
        end
      end
      if (pl_valid) begin
        if (ep_data.size() == 0) chk("pl_unexpected", pl_valid, 1'b0);
        else begin
          chk("pl_data", pl_data, ep_data[0]);
          chk("pl_last", pl_last, ep_last[0]);
          if (pl_ready) begin
            if (pl_last) ol_idx.push_back(pl_cnt);
            pl_cnt++;
            void'(ep_data.pop_front());
            void'(ep_last.pop_front());
          end
        end
      end
      if (b_valid) begin
        if (eb_id.size() == 0) chk("b_unexpected", b_valid, 1'b0);
        else begin
          chk("b_id", b_id, eb_id[0]);
          chk("b_resp", b_resp, eb_resp[0]);
          if (b_ready) begin
            ob_id.push_back(b_id);
            ob_resp.push_back(b_resp);
            void'(eb_id.pop_front());
            void'(eb_resp.pop_front());
          end
        end
      end
    end
  end

  int hb, pb, lb, t;

  initial begin
    // Outputs while reset is held, then release.
    w_valid = 1'b1;
    step(); step();
    chk("rst_aw_ready", aw_ready, 1'b0);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_hdr_valid", hdr_valid, 1'b0);
    chk("rst_pl_valid", pl_valid, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    w_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_aw_ready_pre_edge", aw_ready, 1'b0);
    step();
    chk("rel_aw_ready_post_edge", aw_ready, 1'b1);

    // Single aligned chunk.
    hb = oh_addr.size(); pb = pl_cnt; lb = ol_idx.size();
    run_burst(32'h0000_1000, 3, 4'h3, 3, 1);
    chk("t1_hdr_count", oh_addr.size() - hb, 1);
    chk("t1_hdr_addr", oh_addr[hb], 32'h1000);
    chk("t1_hdr_len", oh_len[hb], 10'd32);
    chk("t1_beats", pl_cnt - pb, 4);
    chk("t1_last_pos", ol_idx[lb], pb + 3);
    chk("t1_resp", ob_resp[ob_resp.size()-1], 2'b00);
    chk("t1_id", ob_id[ob_id.size()-1], 4'h3);

    // Split by chunk limit.
    hb = oh_addr.size();
    run_burst(32'h0000_2000, 9, 4'h5, 9, 2);
    chk("t2_hdr_count", oh_addr.size() - hb, 3);
    chk("t2_h0_addr", oh_addr[hb], 32'h2000);
    chk("t2_h1_addr", oh_addr[hb+1], 32'h2080);
    chk("t2_h2_addr", oh_addr[hb+2], 32'h2100);
    chk("t2_h1_len", oh_len[hb+1], 10'd32);
    chk("t2_h2_len", oh_len[hb+2], 10'd16);
    chk("t2_resp", ob_resp[ob_resp.size()-1], 2'b00);

    // Split at the 4 KB line.
    hb = oh_addr.size(); pb = pl_cnt; lb = ol_idx.size();
    run_burst(32'h0000_0FC0, 3, 4'h1, 3, 3);
    chk("t3_hdr_count", oh_addr.size() - hb, 2);
    chk("t3_h0", {oh_addr[hb], 6'b0, oh_len[hb]}, {32'h0FC0, 16'd16});
    chk("t3_h1", {oh_addr[hb+1], 6'b0, oh_len[hb+1]}, {32'h1000, 16'd16});
    chk("t3_last0", ol_idx[lb], pb + 1);
    chk("t3_last1", ol_idx[lb+1], pb + 3);

    // Early w_last: all beats still forwarded, SLVERR.
    pb = pl_cnt;
    run_burst(32'h0000_3000, 3, 4'h9, 1, 4);
    chk("t4_beats", pl_cnt - pb, 4);
    chk("t4_resp", ob_resp[ob_resp.size()-1], 2'b10);
    chk("t4_id", ob_id[ob_id.size()-1], 4'h9);

    // Header and payload backpressure.
    pb = pl_cnt; lb = ol_idx.size();
    fork
      run_burst(32'h0000_4000, 7, 4'h6, 7, 6);
      begin
        hdr_ready = 1'b0;
        repeat (4) step();
        chk("t5_hdr_held", hdr_valid, 1'b1);
        hdr_ready = 1'b1;
        t = 0;
        while (pl_cnt < pb + 2 && t < 100) begin step(); t++; end
        chk("t5_reach_mid", pl_cnt >= pb + 2, 1'b1);
        pl_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("t5_stall_w_ready", w_ready, 1'b0);
          step();
        end
        pl_ready = 1'b1;
      end
    join
    chk("t5_beats", pl_cnt - pb, 8);
    chk("t5_last0", ol_idx[lb], pb + 3);
    chk("t5_last1", ol_idx[lb+1], pb + 7);

    // 256-beat burst from an unaligned start just below a 4 KB line.
    hb = oh_addr.size(); pb = pl_cnt;
    run_burst(32'h0000_5FE3, 255, 4'hC, 255, 7);
    chk("t6_hdr_count", oh_addr.size() - hb, 65);
    chk("t6_first", {oh_addr[hb], 6'b0, oh_len[hb]}, {32'h5FE0, 16'd8});
    chk("t6_second", oh_addr[hb+1], 32'h6000);
    chk("t6_final", {oh_addr[hb+64], 6'b0, oh_len[hb+64]}, {32'h7F80, 16'd24});
    chk("t6_beats", pl_cnt - pb, 256);

    // Address wrap at the top of the space.
    hb = oh_addr.size();
    run_burst(32'hFFFF_FFC0, 3, 4'h2, 3, 8);
    chk("t7_h0_addr", oh_addr[hb], 32'hFFFF_FFC0);
    chk("t7_h1_addr", oh_addr[hb+1], 32'h0000_0000);

    // Reset during DATA abandons the burst; a new one then completes.
    model_burst(32'h0000_8000, 7, 4'h4, 7, 9);
    send_aw(32'h0000_8000, 7, 4'h4);
    send_beat(9, 0, 1'b0);
    send_beat(9, 1, 1'b0);
    w_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("t8_rst_aw_ready", aw_ready, 1'b0);
    chk("t8_rst_w_ready", w_ready, 1'b0);
    chk("t8_rst_hdr_valid", hdr_valid, 1'b0);
    chk("t8_rst_pl_valid", pl_valid, 1'b0);
    chk("t8_rst_b_valid", b_valid, 1'b0);
    eh_addr.delete(); eh_len.delete(); ep_data.delete(); ep_last.delete();
    eb_id.delete(); eb_resp.delete();
    w_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("t8_aw_ready_pre_edge", aw_ready, 1'b0);
    step();
    chk("t8_aw_ready_post_edge", aw_ready, 1'b1);
    repeat (4) step();
    hb = oh_addr.size();
    run_burst(32'h0000_9000, 1, 4'hE, 1, 10);
    chk("t8_new_hdr", {oh_addr[hb], 6'b0, oh_len[hb]}, {32'h9000, 16'd16});
    chk("t8_new_resp", {ob_id[ob_id.size()-1], ob_resp[ob_resp.size()-1]}, {4'hE, 2'b00});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
